// File: rtl/nios1_pio_pkg.sv
// Shared constants, bus payload type and helpers for the parametrised Nios II input PIO.
package nios1_pio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pio_req_t;

  // Debounce counter width: holds 0..n so it never wraps.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Pick which transitions count as captured edges.
  function automatic logic [DATA_W-1:0] sel_edges(input logic [DATA_W-1:0] rise,
                                                  input logic [DATA_W-1:0] fall,
                                                  input int unsigned       edge_type);
    logic [DATA_W-1:0] res;
    res = rise;
    case (edge_type)
      EDGE_RISE: res = rise;
      EDGE_FALL: res = fall;
      EDGE_ANY:  res = rise | fall;
      default:   res = rise;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nios1_pio_debounce.sv
// One-bit debouncer: the output follows the synchronised input only after it has held
// a new level for N consecutive clocks; N=0 is a plain register.
module nios1_pio_debounce
  import nios1_pio_pkg::*;
#(
  parameter int unsigned N = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_stable
);

  logic r_stable;

  if (N == 0) begin : g_bypass
    always_ff @(posedge clk) begin
      if (reset) r_stable <= 1'b0;
      else       r_stable <= i_sync;
    end
  end else begin : g_filter
    localparam int unsigned CW = cnt_width(N);
    logic [CW-1:0] r_cnt;

    // Count consecutive clocks the input disagrees with the stable level.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (i_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(N - 1)) begin
        r_stable <= i_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/nios1_pio_in_irq.sv
// Avalon-MM input PIO: synchronises and debounces inputs, captures edges per bit and
// raises a masked level interrupt.
module nios1_pio_in_irq
  import nios1_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic [31:0] RESET_MASK      = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_sync2;
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_edge;
  logic [WIDTH-1:0]  r_mask;
  logic [DATA_W-1:0] r_rdata;

  logic [WIDTH-1:0]  w_stable;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  logic [WIDTH-1:0]  w_edges;
  logic [WIDTH-1:0]  w_clr;
  logic [DATA_W-1:0] w_rd_mux;
  pio_req_t          w_req;
  logic              w_unused;

  assign w_req = '{wr: chipselect & ~write_n, addr: address, data: writedata};
  // Write data above WIDTH is intentionally dropped.
  assign w_unused = ^w_req;

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    nios1_pio_debounce #(
      .N(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .i_sync   (r_sync2[gi]),
      .o_stable (w_stable[gi])
    );
  end

  assign w_rise  = w_stable & ~r_prev;
  assign w_fall  = ~w_stable & r_prev;
  assign w_edges = WIDTH'(sel_edges(DATA_W'(w_rise), DATA_W'(w_fall), EDGE_TYPE));
  assign w_clr   = (w_req.wr && (w_req.addr == ADDR_EDGE)) ? w_req.data[WIDTH-1:0] : '0;

  // Read mux is sampled every clock regardless of chipselect.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = DATA_W'(w_stable);
      ADDR_RSVD: w_rd_mux = '0;
      ADDR_MASK: w_rd_mux = DATA_W'(r_mask);
      ADDR_EDGE: w_rd_mux = DATA_W'(r_edge);
      default:   w_rd_mux = '0;
    endcase
  end

  // A new edge outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev  <= '0;
      r_edge  <= '0;
      r_mask  <= WIDTH'(RESET_MASK);
      r_rdata <= '0;
    end else begin
      r_prev  <= w_stable;
      r_edge  <= w_edges | (r_edge & ~w_clr);
      r_rdata <= w_rd_mux;
      if (w_req.wr && (w_req.addr == ADDR_MASK)) begin
        r_mask <= w_req.data[WIDTH-1:0];
      end
    end
  end

  assign readdata = r_rdata;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_nios1_pio_in_irq.sv
// Bench for nios1_pio_in_irq: three configurations on a shared bus, checked every
// cycle against a history-based reference model plus directed corner-case sequences.
module tb_nios1_pio_in_irq;

  localparam int MAXC = 4096;
  localparam logic [31:0] WM [3] = '{32'h0003_FFFF, 32'h0003_FFFF, 32'hFFFF_FFFF};
  localparam int unsigned ET [3] = '{0, 1, 2};
  localparam int unsigned NN [3] = '{0, 4, 0};
  localparam logic [31:0] RM [3] = '{32'h0, 32'h155, 32'h0};

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        cs;
  logic        wn;
  logic [31:0] writedata;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic [31:0] in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int checks = 0;
  int errors = 0;

  nios1_pio_in_irq #(.WIDTH(18), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .RESET_MASK(32'h0)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));
  nios1_pio_in_irq #(.WIDTH(18), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4), .RESET_MASK(32'h155)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b));
  nios1_pio_in_irq #(.WIDTH(32), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0), .RESET_MASK(32'h0)) dut_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-edge histories of the synchronised and stable values.
  logic [31:0] h_s2  [3][MAXC];
  logic [31:0] h_stb [3][MAXC];
  logic [31:0] m_in_prev [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] m_prv [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] m_ec  [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] m_msk [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] m_rd  [3] = '{32'h0, 32'h0, 32'h0};
  logic        m_rst_prev = 1'b1;
  bit          m_valid = 1'b0;
  int          mt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", nm, got, exp, mt);
    end
  endtask

  function automatic logic [31:0] get_in(input int i);
    case (i)
      0:       return 32'(in_a);
      1:       return 32'(in_b);
      default: return in_c;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int i);
    case (i)
      0:       return rd_a;
      1:       return rd_b;
      default: return rd_c;
    endcase
  endfunction

  function automatic logic get_irq(input int i);
    case (i)
      0:       return irq_a;
      1:       return irq_b;
      default: return irq_c;
    endcase
  endfunction

  task automatic model_step();
    logic        wr;
    logic [31:0] s2, so, sn, ones, zeros, v, rise, fall, edg, clr;
    if (mt >= MAXC) begin
      errors++;
      $display("FAIL model_overflow cycle=%0d limit=%0d", mt, MAXC);
      $fatal(1, "model history exhausted");
    end
    wr = cs & ~wn;
    for (int i = 0; i < 3; i++) begin
      // Input reaches the second sync stage one edge after being sampled.
      s2 = (reset || m_rst_prev) ? 32'h0 : m_in_prev[i];
      so = (mt > 0) ? h_stb[i][mt-1] : 32'h0;
      if (reset) begin
        sn = 32'h0;
      end else if (NN[i] == 0) begin
        sn = (mt > 0) ? h_s2[i][mt-1] : 32'h0;
      end else begin
        ones  = 32'hFFFF_FFFF;
        zeros = 32'hFFFF_FFFF;
        for (int k = 1; k <= int'(NN[i]); k++) begin
          v     = (mt >= k) ? h_s2[i][mt-k] : 32'h0;
          ones  = ones & v;
          zeros = zeros & ~v;
        end
        sn = (so & ~zeros) | ones;
      end
      rise = so & ~m_prv[i];
      fall = ~so & m_prv[i];
      edg  = (ET[i] == 0) ? rise : (ET[i] == 1) ? fall : (rise | fall);
      clr  = (wr && address == 2'd3) ? (writedata & WM[i]) : 32'h0;
      if (reset) begin
        m_rd[i]  = 32'h0;
        m_ec[i]  = 32'h0;
        m_msk[i] = RM[i];
        m_prv[i] = 32'h0;
      end else begin
        case (address)
          2'd0:    m_rd[i] = so;
          2'd2:    m_rd[i] = m_msk[i];
          2'd3:    m_rd[i] = m_ec[i];
          default: m_rd[i] = 32'h0;
        endcase
        m_ec[i] = (edg | (m_ec[i] & ~clr)) & WM[i];
        if (wr && address == 2'd2) m_msk[i] = writedata & WM[i];
        m_prv[i] = so;
      end
      h_s2[i][mt]  = s2;
      h_stb[i][mt] = sn;
      m_in_prev[i] = get_in(i) & WM[i];
    end
    m_rst_prev = reset;
    mt++;
    if (reset) m_valid = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_rd%0d", i), get_rd(i), m_rd[i]);
        chk($sformatf("model_irq%0d", i), 32'(get_irq(i)), 32'(|(m_ec[i] & m_msk[i])));
      end
    end
  endtask

  task automatic idle(input int n);
    cs = 1'b0;
    wn = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    cs        = 1'b1;
    wn        = 1'b0;
    cyc();
    cs = 1'b0;
    wn = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a;
    cs      = 1'b1;
    wn      = 1'b1;
    cyc();
    cs = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } rd_vec_t;

  rd_vec_t rst_vec [4];

  initial begin
    rst_vec[0] = '{addr: 2'd0, exp_a: 32'h3FFFF, exp_b: 32'h3FFFF};
    rst_vec[1] = '{addr: 2'd1, exp_a: 32'h0,     exp_b: 32'h0};
    rst_vec[2] = '{addr: 2'd2, exp_a: 32'h0,     exp_b: 32'h155};
    rst_vec[3] = '{addr: 2'd3, exp_a: 32'h3FFFF, exp_b: 32'h0};

    reset = 1'b1; cs = 1'b0; wn = 1'b1; address = 2'd0; writedata = 32'h0;
    in_a = '1; in_b = '1; in_c = 32'h0;
    repeat (3) cyc();
    chk("reset_irq_a", 32'(irq_a), 32'h0);
    chk("reset_rd_a", rd_a, 32'h0);
    reset = 1'b0;
    idle(10);

    // Reset-release with inputs held high.
    foreach (rst_vec[j]) begin
      bus_rd(rst_vec[j].addr);
      chk($sformatf("rst_tbl_a_addr%0d", rst_vec[j].addr), rd_a, rst_vec[j].exp_a);
      chk($sformatf("rst_tbl_b_addr%0d", rst_vec[j].addr), rd_b, rst_vec[j].exp_b);
    end
    bus_wr(2'd3, 32'hFFFF_FFFF);

    // Rising edge latency and W1C.
    in_a = '0;
    idle(6);
    bus_wr(2'd2, 32'h1);
    address = 2'd3;
    in_a[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk($sformatf("rise_irq_k%0d", j), 32'(irq_a), (j == 3) ? 32'h1 : 32'h0);
    end
    cyc();
    chk("rise_ec", rd_a, 32'h1);
    bus_wr(2'd3, 32'h1);
    chk("w1c_irq", 32'(irq_a), 32'h0);

    // Mask gating, then edge-versus-clear race.
    bus_wr(2'd2, 32'h0);
    in_a[5] = 1'b1;
    idle(5);
    bus_rd(2'd3);
    chk("mask0_ec", rd_a, 32'h20);
    chk("mask0_irq", 32'(irq_a), 32'h0);
    bus_wr(2'd2, 32'h20);
    chk("mask_irq", 32'(irq_a), 32'h1);
    in_a[5] = 1'b0;
    idle(5);
    bus_wr(2'd3, 32'h20);
    chk("clr_irq", 32'(irq_a), 32'h0);
    in_a[5] = 1'b1;
    cyc(); cyc(); cyc();
    bus_wr(2'd3, 32'h20);
    chk("race_irq", 32'(irq_a), 32'h1);
    bus_rd(2'd3);
    chk("race_ec", rd_a, 32'h20);
    bus_wr(2'd3, 32'h20);
    chk("rd_preclear", rd_a, 32'h20);
    bus_rd(2'd3);
    chk("post_clear", rd_a, 32'h0);

    // Debounce: 3-clock glitch is rejected, 4-clock hold is accepted.
    address = 2'd0;
    in_b[2] = 1'b0;
    cyc(); cyc(); cyc();
    in_b[2] = 1'b1;
    idle(10);
    bus_rd(2'd0);
    chk("glitch_data_b", rd_b, 32'h3FFFF);
    bus_rd(2'd3);
    chk("glitch_ec_b", rd_b, 32'h0);
    address = 2'd0;
    in_b[2] = 1'b0;
    for (int j = 0; j < 7; j++) begin
      cyc();
      chk($sformatf("db_hold_k%0d", j), 32'(rd_b[2]), (j == 6) ? 32'h0 : 32'h1);
    end
    idle(2);
    bus_rd(2'd3);
    chk("db_fall_ec_b", rd_b, 32'h4);

    // Any-edge on the top bit of a full-width instance.
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'h8000_0000);
    in_c[31] = 1'b1;
    idle(5);
    bus_rd(2'd3);
    chk("c_rise_ec", rd_c, 32'h8000_0000);
    chk("c_rise_irq", 32'(irq_c), 32'h1);
    bus_rd(2'd0);
    chk("c_data", rd_c, 32'h8000_0000);
    bus_wr(2'd3, 32'h8000_0000);
    chk("c_clr1_irq", 32'(irq_c), 32'h0);
    in_c[31] = 1'b0;
    idle(5);
    bus_rd(2'd3);
    chk("c_fall_ec", rd_c, 32'h8000_0000);
    bus_wr(2'd3, 32'h8000_0000);
    bus_rd(2'd3);
    chk("c_clr2_ec", rd_c, 32'h0);

    // Reset in the middle of operation.
    in_a = '0;
    idle(5);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'hFF);
    in_a = 18'hFF;
    idle(5);
    bus_rd(2'd3);
    chk("pre_rst_ec", rd_a, 32'hFF);
    chk("pre_rst_irq", 32'(irq_a), 32'h1);
    reset = 1'b1;
    cyc();
    chk("midrst_irq", 32'(irq_a), 32'h0);
    chk("midrst_rd", rd_a, 32'h0);
    cyc();
    reset = 1'b0;
    bus_rd(2'd2);
    chk("midrst_mask", rd_a, 32'h0);
    bus_rd(2'd3);
    chk("midrst_ec", rd_a, 32'h0);
    idle(4);
    bus_rd(2'd3);
    chk("held_high_edge", rd_a, 32'hFF);
    chk("held_high_irq", 32'(irq_a), 32'h0);

    // Randomised traffic checked cycle by cycle against the model.
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      cs        = 1'($urandom_range(0, 1));
      wn        = 1'($urandom_range(0, 1));
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom();
      if ($urandom_range(0, 3) == 0) in_a = in_a ^ (18'(1) << $urandom_range(0, 17));
      if ($urandom_range(0, 5) == 0) in_b = in_b ^ (18'(1) << $urandom_range(0, 17));
      if ($urandom_range(0, 3) == 0) in_c = in_c ^ (32'(1) << $urandom_range(0, 31));
      cyc();
    end
    reset = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
